// File: rtl/shared_mailbox_pkg.sv
// Shared definitions for the N-port mailbox: default address map, access kinds
// and the window address decoder used by the top level.
package shared_mailbox_pkg;

    localparam logic [21:0] DEF_MEM_BASE    = 22'h2000;
    localparam logic [21:0] DEF_SWITCH_ADDR = 22'h2400;
    localparam logic [31:0] DEF_SWITCH_INIT = 32'hab;

    typedef enum logic {
        ACC_READ  = 1'b0,
        ACC_WRITE = 1'b1
    } acc_kind_e;

    typedef struct packed {
        logic        in_range;
        logic [31:0] idx;
        logic [31:0] owner;
    } dec_t;

    // idx is only meaningful when in_range; owner is the window holding idx.
    function automatic dec_t decode_addr(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] span,
                                         input int unsigned win_log2);
        dec_t d;
        d.idx      = addr - base;
        d.in_range = (addr >= base) && (d.idx < span);
        d.owner    = d.idx >> win_log2;
        return d;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority restarts just after the last
// granted port; the pointer holds while nobody requests.
module rr_arbiter #(
    parameter  int NUM_PORTS = 2,
    localparam int PW        = $clog2(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [PW-1:0]        gnt_idx,
    output logic                 gnt_vld
);

    logic [PW-1:0] ptr_q, ptr_d;

    function automatic logic [PW-1:0] wrap(input int k);
        return PW'((k >= NUM_PORTS) ? k - NUM_PORTS : k);
    endfunction

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (rst_n && !gnt_vld && req[wrap(int'(ptr_q) + i)]) begin
                gnt_vld = 1'b1;
                gnt_idx = wrap(int'(ptr_q) + i);
            end
        end
        if (gnt_vld) gnt[gnt_idx] = 1'b1;
        ptr_d = gnt_vld ? wrap(int'(gnt_idx) + 1) : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/shared_mailbox.sv
// N-port shared mailbox: one arbitrated single-port RAM, per-port write windows,
// doorbell flags and a switch-board info word. Read results return two cycles after grant.
module shared_mailbox
    import shared_mailbox_pkg::*;
#(
    parameter int                NUM_PORTS   = 2,
    parameter int                ADDR_W      = 22,
    parameter int                DATA_W      = 32,
    parameter int                WIN_WORDS   = 512,
    parameter logic [ADDR_W-1:0] MEM_BASE    = ADDR_W'(DEF_MEM_BASE),
    parameter logic [ADDR_W-1:0] SWITCH_ADDR = ADDR_W'(DEF_SWITCH_ADDR),
    parameter logic [DATA_W-1:0] SWITCH_INIT = DATA_W'(DEF_SWITCH_INIT)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS-1:0]        req_re,
    input  logic [NUM_PORTS-1:0]        req_we,
    input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]        req_ack,
    output logic [NUM_PORTS*DATA_W-1:0] rd_data,
    output logic [NUM_PORTS-1:0]        rd_valid,
    output logic [NUM_PORTS-1:0]        acc_err,
    input  logic [DATA_W-1:0]           sw_info_in,
    input  logic                        sw_info_we,
    output logic [NUM_PORTS-1:0]        pending
);

    localparam int PW        = $clog2(NUM_PORTS);
    localparam int WIN_LOG2  = $clog2(WIN_WORDS);
    localparam int RAM_WORDS = NUM_PORTS * WIN_WORDS;
    localparam int RAM_AW    = $clog2(RAM_WORDS);

    logic [NUM_PORTS-1:0] gnt;
    logic [PW-1:0]        gnt_idx;
    logic                 gnt_vld;

    rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_re | req_we),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    assign req_ack = gnt;

    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    acc_kind_e         g_kind;
    dec_t              dec;
    logic              is_sw, own_win, last_word, wr_ok, rd_clr;
    logic [RAM_AW-1:0] ram_idx;
    logic [PW-1:0]     owner_idx;
    logic              unused_dec;

    always_comb begin
        g_addr  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
        g_wdata = req_wdata[gnt_idx*DATA_W +: DATA_W];
        g_kind  = req_we[gnt_idx] ? ACC_WRITE : ACC_READ;
        dec     = decode_addr(32'(g_addr), 32'(MEM_BASE), 32'(RAM_WORDS), WIN_LOG2);
    end

    assign is_sw      = (g_addr == SWITCH_ADDR);
    assign own_win    = (dec.owner == 32'(gnt_idx));
    assign last_word  = &dec.idx[WIN_LOG2-1:0];
    assign ram_idx    = dec.idx[RAM_AW-1:0];
    assign owner_idx  = dec.owner[PW-1:0];
    assign wr_ok      = gnt_vld && (g_kind == ACC_WRITE) && dec.in_range && own_win;
    // Only a non-owner reading the doorbell word acknowledges the message.
    assign rd_clr     = gnt_vld && (g_kind == ACC_READ) && dec.in_range && last_word && !own_win;
    assign unused_dec = ^{dec.idx, dec.owner};

    logic [DATA_W-1:0] mem [RAM_WORDS];
    logic [DATA_W-1:0] ram_rd_q;

    always_ff @(posedge clk) begin
        if (gnt_vld) begin
            if (wr_ok) mem[ram_idx] <= g_wdata;
            ram_rd_q <= mem[ram_idx];
        end
    end

    logic [NUM_PORTS-1:0]             pending_q, pending_d;
    logic [DATA_W-1:0]                sw_q, sw_d;
    logic                             s1_vld_q, s1_vld_d, s1_rd_q, s1_rd_d;
    logic                             s1_err_q, s1_err_d, s1_ram_q, s1_ram_d;
    logic [PW-1:0]                    s1_port_q, s1_port_d;
    logic [DATA_W-1:0]                s1_data_q, s1_data_d;
    logic [NUM_PORTS-1:0]             rd_valid_q, rd_valid_d, acc_err_q, acc_err_d;
    logic [NUM_PORTS-1:0][DATA_W-1:0] rd_data_q, rd_data_d;

    always_comb begin
        pending_d = pending_q;
        if (wr_ok && last_word) pending_d[owner_idx] = 1'b1;
        if (rd_clr)             pending_d[owner_idx] = 1'b0;
        sw_d = sw_info_we ? sw_info_in : sw_q;

        // Switch word is sampled before this edge's load, so a same-cycle read sees the old value.
        s1_vld_d  = gnt_vld;
        s1_rd_d   = (g_kind == ACC_READ);
        s1_port_d = gnt_idx;
        s1_ram_d  = dec.in_range;
        s1_data_d = is_sw ? sw_q : '0;
        s1_err_d  = (g_kind == ACC_WRITE) ? !wr_ok : !(dec.in_range || is_sw);

        rd_valid_d = '0;
        acc_err_d  = '0;
        rd_data_d  = rd_data_q;
        if (s1_vld_q) begin
            acc_err_d[s1_port_q] = s1_err_q;
            if (s1_rd_q) begin
                rd_valid_d[s1_port_q] = 1'b1;
                rd_data_d[s1_port_q]  = s1_ram_q ? ram_rd_q : s1_data_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q  <= '0;
            sw_q       <= SWITCH_INIT;
            s1_vld_q   <= 1'b0;
            s1_rd_q    <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_ram_q   <= 1'b0;
            s1_port_q  <= '0;
            s1_data_q  <= '0;
            rd_valid_q <= '0;
            acc_err_q  <= '0;
            rd_data_q  <= '0;
        end else begin
            pending_q  <= pending_d;
            sw_q       <= sw_d;
            s1_vld_q   <= s1_vld_d;
            s1_rd_q    <= s1_rd_d;
            s1_err_q   <= s1_err_d;
            s1_ram_q   <= s1_ram_d;
            s1_port_q  <= s1_port_d;
            s1_data_q  <= s1_data_d;
            rd_valid_q <= rd_valid_d;
            acc_err_q  <= acc_err_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign pending  = pending_q;
    assign rd_valid = rd_valid_q;
    assign acc_err  = acc_err_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_shared_mailbox.sv
// Bench for shared_mailbox: directed scenarios plus random traffic, all checked
// cycle by cycle against a behavioural model of the mailbox rules.
module tb_shared_mailbox;

    localparam int N = 4, AW = 22, DW = 32, WW = 512;
    localparam logic [AW-1:0] MB = 22'h2000, SA = 22'h3000;
    localparam logic [DW-1:0] SI = 32'hab;
    localparam int OBS_W = 4*N + N*DW;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0][AW-1:0] addr_r;
    logic [N-1:0][DW-1:0] wd_r;
    logic [N-1:0]         re_r, we_r;
    logic [DW-1:0]        sw_in_r;
    logic                 sw_we_r;
    logic [N*AW-1:0]      req_addr_b;
    logic [N*DW-1:0]      req_wdata_b, rd_data;
    logic [N-1:0]         req_ack, rd_valid, acc_err, pending;

    assign req_addr_b  = addr_r;
    assign req_wdata_b = wd_r;

    shared_mailbox #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .WIN_WORDS(WW),
                     .MEM_BASE(MB), .SWITCH_ADDR(SA), .SWITCH_INIT(SI)) dut (
        .clk(clk), .rst_n(rst_n), .req_addr(req_addr_b), .req_re(re_r), .req_we(we_r),
        .req_wdata(req_wdata_b), .req_ack(req_ack), .rd_data(rd_data), .rd_valid(rd_valid),
        .acc_err(acc_err), .sw_info_in(sw_in_r), .sw_info_we(sw_we_r), .pending(pending)
    );

    // Reference model state
    logic [DW-1:0]        mem_m [N*WW];
    bit                   written [N*WW];
    logic [N-1:0]         pend_m, out_vld, out_err;
    logic [N-1:0][DW-1:0] out_data;
    logic [DW-1:0]        sw_m, p1_data;
    bit                   p1_vld, p1_rd, p1_err;
    int                   p1_port, ptr_m, g_m;
    logic [OBS_W-1:0]     exp_obs;
    int n_vec = 0, n_err = 0;

    task automatic req(input int p, input logic r, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
        re_r[p] = r; we_r[p] = w; addr_r[p] = a; wd_r[p] = d;
    endtask

    task automatic idle_all();
        re_r = '0; we_r = '0; sw_we_r = 1'b0;
    endtask

    task automatic mdl_reset();
        pend_m = '0; sw_m = SI; ptr_m = 0; p1_vld = 0;
        out_vld = '0; out_err = '0; out_data = '0;
    endtask

    // Predicts this cycle's visible outputs, then applies this cycle's grant.
    task automatic mdl_cycle();
        logic [N-1:0]  gv;
        logic [AW-1:0] a;
        bit            inr;
        int            idx, own;
        gv = '0; g_m = -1;
        if (rst_n)
            for (int i = 0; i < N; i++)
                if (g_m < 0 && (re_r[(ptr_m+i)%N] || we_r[(ptr_m+i)%N])) g_m = (ptr_m+i)%N;
        if (g_m >= 0) gv[g_m] = 1'b1;
        exp_obs = {gv, out_vld, out_err, pend_m, out_data};
        if (!rst_n) begin
            mdl_reset();
            return;
        end
        out_vld = '0; out_err = '0;
        if (p1_vld) begin
            out_err[p1_port] = p1_err;
            if (p1_rd) begin
                out_vld[p1_port]  = 1'b1;
                out_data[p1_port] = p1_data;
            end
        end
        p1_vld = 0;
        if (g_m >= 0) begin
            a   = addr_r[g_m];
            inr = (a >= MB) && (int'(a - MB) < N*WW);
            idx = inr ? int'(a - MB) : 0;
            own = idx / WW;
            p1_vld = 1; p1_port = g_m; p1_rd = !we_r[g_m]; p1_data = '0;
            if (we_r[g_m]) begin
                p1_err = !(inr && own == g_m);
                if (!p1_err) begin
                    mem_m[idx] = wd_r[g_m];
                    written[idx] = 1;
                    if (idx % WW == WW-1) pend_m[own] = 1'b1;
                end
            end else if (inr) begin
                p1_err = 0; p1_data = mem_m[idx];
                if (idx % WW == WW-1 && own != g_m) pend_m[own] = 1'b0;
            end else if (a == SA) begin
                p1_err = 0; p1_data = sw_m;
            end else begin
                p1_err = 1;
            end
            ptr_m = (g_m + 1) % N;
        end
        if (sw_we_r) sw_m = sw_in_r;
    endtask

    task automatic drop_acked();
        if (g_m >= 0) begin
            re_r[g_m] = 1'b0; we_r[g_m] = 1'b0;
        end
    endtask

    task automatic test_reset();
        idle_all();
        re_r = '1;
        for (int p = 0; p < N; p++) addr_r[p] = SA;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({req_ack, rd_valid, acc_err, pending, rd_data} !== '0) begin
            n_err++;
            $display("FAIL reset_state got %h want 0", {req_ack, rd_valid, acc_err, pending, rd_data});
        end
        mdl_reset();
        @(posedge clk); #1;
        idle_all();
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        for (int c = 0; c < 5; c++) begin
            case (c)
                0: req(0, 0, 1, MB + 5, 32'hdeadbeef);
                1: req(1, 1, 0, MB + 5, 0);
                default: ;
            endcase
            @(negedge clk); mdl_cycle(); n_vec++;
            if ({req_ack, rd_valid, acc_err, pending, rd_data} !== exp_obs) begin
                n_err++;
                $display("FAIL write_read c=%0d got %h want %h", c, {req_ack, rd_valid, acc_err, pending, rd_data}, exp_obs);
            end
            if (c == 3) begin
                n_vec++;
                if (rd_valid !== 4'b0010 || rd_data[32 +: 32] !== 32'hdeadbeef || acc_err !== 4'b0) begin
                    n_err++;
                    $display("FAIL write_read_data vld=%b data=%h err=%b want 0010/deadbeef/0000", rd_valid, rd_data[32 +: 32], acc_err);
                end
            end
            @(posedge clk); #1; drop_acked();
        end
    endtask

    task automatic test_protect();
        for (int c = 0; c < 7; c++) begin
            case (c)
                0: req(1, 0, 1, MB + 5, 32'h1234);
                3: req(2, 1, 0, MB + 5, 0);
                default: ;
            endcase
            @(negedge clk); mdl_cycle(); n_vec++;
            if ({req_ack, rd_valid, acc_err, pending, rd_data} !== exp_obs) begin
                n_err++;
                $display("FAIL protect c=%0d got %h want %h", c, {req_ack, rd_valid, acc_err, pending, rd_data}, exp_obs);
            end
            if (c == 2 || c == 5) begin
                n_vec++;
                if ((c == 2 && (acc_err !== 4'b0010 || rd_valid !== 4'b0)) ||
                    (c == 5 && (rd_valid !== 4'b0100 || rd_data[64 +: 32] !== 32'hdeadbeef))) begin
                    n_err++;
                    $display("FAIL protect_check c=%0d err=%b vld=%b data=%h", c, acc_err, rd_valid, rd_data[64 +: 32]);
                end
            end
            @(posedge clk); #1; drop_acked();
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0] want;
        for (int c = 0; c < 12; c++) begin
            rst_n = (c != 0);
            if (c >= 1 && c <= 8)
                for (int p = 0; p < N; p++) req(p, 1, 0, SA, 0);
            else
                idle_all();
            @(negedge clk); mdl_cycle(); n_vec++;
            if ({req_ack, rd_valid, acc_err, pending, rd_data} !== exp_obs) begin
                n_err++;
                $display("FAIL fairness c=%0d got %h want %h", c, {req_ack, rd_valid, acc_err, pending, rd_data}, exp_obs);
            end
            if (c >= 1 && c <= 8) begin
                want = '0;
                want[(c-1) % N] = 1'b1;
                n_vec++;
                if (req_ack !== want) begin
                    n_err++;
                    $display("FAIL fairness_order c=%0d ack=%b want %b", c, req_ack, want);
                end
            end
            @(posedge clk); #1; drop_acked();
        end
    endtask

    task automatic test_doorbell();
        for (int c = 0; c < 6; c++) begin
            case (c)
                0: req(0, 0, 1, MB + 511, 32'h77);
                1: req(0, 1, 0, MB + 511, 0);
                3: req(1, 1, 0, MB + 511, 0);
                default: ;
            endcase
            @(negedge clk); mdl_cycle(); n_vec++;
            if ({req_ack, rd_valid, acc_err, pending, rd_data} !== exp_obs) begin
                n_err++;
                $display("FAIL doorbell c=%0d got %h want %h", c, {req_ack, rd_valid, acc_err, pending, rd_data}, exp_obs);
            end
            if (c == 1 || c == 2 || c == 4 || c == 5) begin
                n_vec++;
                if ((c <= 2 && pending !== 4'b0001) || (c == 4 && pending !== 4'b0000) ||
                    (c == 5 && rd_data[32 +: 32] !== 32'h77)) begin
                    n_err++;
                    $display("FAIL doorbell_check c=%0d pending=%b data1=%h", c, pending, rd_data[32 +: 32]);
                end
            end
            @(posedge clk); #1; drop_acked();
        end
    endtask

    task automatic test_switch();
        for (int c = 0; c < 9; c++) begin
            case (c)
                0: req(2, 1, 0, SA, 0);
                1: begin req(2, 1, 0, SA, 0); sw_we_r = 1'b1; sw_in_r = 32'h55; end
                2: begin req(2, 1, 0, SA, 0); sw_we_r = 1'b0; end
                4: req(2, 0, 1, SA, 32'h99);
                6: req(2, 1, 0, SA, 0);
                default: ;
            endcase
            @(negedge clk); mdl_cycle(); n_vec++;
            if ({req_ack, rd_valid, acc_err, pending, rd_data} !== exp_obs) begin
                n_err++;
                $display("FAIL switch c=%0d got %h want %h", c, {req_ack, rd_valid, acc_err, pending, rd_data}, exp_obs);
            end
            if (c == 2 || c == 3 || c == 4 || c == 6 || c == 8) begin
                n_vec++;
                if (((c == 2 || c == 3) && rd_data[64 +: 32] !== 32'hab) ||
                    ((c == 4 || c == 8) && rd_data[64 +: 32] !== 32'h55) ||
                    (c == 6 && acc_err !== 4'b0100)) begin
                    n_err++;
                    $display("FAIL switch_check c=%0d data2=%h err=%b", c, rd_data[64 +: 32], acc_err);
                end
            end
            @(posedge clk); #1; drop_acked();
        end
    endtask

    task automatic test_reset_mid_read();
        for (int c = 0; c < 6; c++) begin
            case (c)
                0: req(1, 1, 0, MB + 5, 0);
                1: rst_n = 1'b0;
                2: begin rst_n = 1'b1; req(0, 1, 0, SA, 0); req(3, 1, 0, SA, 0); end
                default: ;
            endcase
            @(negedge clk); mdl_cycle(); n_vec++;
            if ({req_ack, rd_valid, acc_err, pending, rd_data} !== exp_obs) begin
                n_err++;
                $display("FAIL reset_mid c=%0d got %h want %h", c, {req_ack, rd_valid, acc_err, pending, rd_data}, exp_obs);
            end
            if (c >= 2 && c <= 4) begin
                n_vec++;
                if ((c == 2 && ({rd_valid, acc_err, pending, rd_data} !== '0 || req_ack !== 4'b0001)) ||
                    (c == 3 && req_ack !== 4'b1000) ||
                    (c == 4 && (rd_valid !== 4'b0001 || rd_data[0 +: 32] !== 32'hab))) begin
                    n_err++;
                    $display("FAIL reset_mid_check c=%0d ack=%b vld=%b data0=%h", c, req_ack, rd_valid, rd_data[0 +: 32]);
                end
            end
            @(posedge clk); #1; drop_acked();
        end
    endtask

    task automatic test_random();
        int k, idx, off;
        bit w;
        logic [AW-1:0] a;
        for (int c = 0; c < 404; c++) begin
            if (c < 400) begin
                sw_we_r = ($urandom % 8 == 0);
                sw_in_r = $urandom;
                for (int p = 0; p < N; p++) begin
                    if (!re_r[p] && !we_r[p] && ($urandom % 2 == 1)) begin
                        k   = $urandom % 16;
                        off = (k % 3 == 0) ? 0 : (k % 3 == 1) ? 7 : WW - 1;
                        idx = (k / 3) * WW + off;
                        a   = (k < 12) ? MB + AW'(idx) : (k < 14) ? SA : (k == 14) ? MB - 1 : MB + AW'(N*WW);
                        w   = $urandom % 2;
                        if (!w && k < 12 && !written[idx]) w = 1;
                        req(p, !w || ($urandom % 4 == 0), w, a, $urandom);
                    end
                end
            end else begin
                idle_all();
            end
            @(negedge clk); mdl_cycle(); n_vec++;
            if ({req_ack, rd_valid, acc_err, pending, rd_data} !== exp_obs) begin
                n_err++;
                $display("FAIL random c=%0d got %h want %h", c, {req_ack, rd_valid, acc_err, pending, rd_data}, exp_obs);
            end
            @(posedge clk); #1; drop_acked();
        end
    endtask

    initial begin
        idle_all();
        addr_r = '0; wd_r = '0; sw_in_r = '0;
        test_reset();
        test_write_read();
        test_protect();
        test_fairness();
        test_doorbell();
        test_switch();
        test_reset_mid_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
